// File: rtl/xvga_timing.sv
// ----------------------------------------------------------------------------
// xvga_timing
//
// XVGA raster timing generator. Produces pixel/line counters with aligned
// hsync, vsync and blank. It also produces copies of sync/blank delayed by
// SYNC_DELAY clocks, so monitor-side signals can match the compositor's
// sprite ROM latency. A frame tick and an 8-bit frame counter support
// game-logic animation.
//
// Ports
//   clock          in   1   pixel clock
//   reset          in   1   asynchronous, active-low reset
//   hcount         out  11  horizontal pixel index, 0..H_TOTAL-1
//   vcount         out  10  vertical line index, 0..V_TOTAL-1
//   hsync          out  1   horizontal sync, active low, aligned with hcount
//   vsync          out  1   vertical sync, active low, aligned with vcount
//   blank          out  1   1 outside the active area, aligned with counters
//   hsync_d        out  1   hsync delayed SYNC_DELAY clocks
//   vsync_d        out  1   vsync delayed SYNC_DELAY clocks
//   blank_d        out  1   blank delayed SYNC_DELAY clocks
//   frame_tick     out  1   one-clock pulse when the raster returns to (0,0)
//   frame_count    out  8   frames elapsed, wraps 255->0
//   pattern_pixel  out  12  colour-bar test pattern, aligned with blank_d
//
// Build option
//   XVGA_TEST_PATTERN_EN : when defined, pattern_pixel carries an 8-bar
//                          colour pattern. When undefined, pattern_pixel is
//                          tied to 12'h000 and no pattern logic exists.
//
// Parameter limits: H_TOTAL <= 2048 and V_TOTAL <= 1024 (counter widths).
// ----------------------------------------------------------------------------
module xvga_timing #(
    parameter int H_ACTIVE   = 1024,
    parameter int H_FP       = 24,
    parameter int H_SYNC     = 136,
    parameter int H_BP       = 160,
    parameter int V_ACTIVE   = 768,
    parameter int V_FP       = 3,
    parameter int V_SYNC     = 6,
    parameter int V_BP       = 29,
    parameter int SYNC_DELAY = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic [10:0] hcount,
    output logic [9:0]  vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic        hsync_d,
    output logic        vsync_d,
    output logic        blank_d,
    output logic        frame_tick,
    output logic [7:0]  frame_count,
    output logic [11:0] pattern_pixel
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // All boundaries are held one bit wider than the counters so that an end
    // bound equal to the full counter range (e.g. 2048) compares correctly.
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_ACT_W  = 12'(H_ACTIVE);
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_ACT_W  = 11'(V_ACTIVE);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    logic [10:0] hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;
    logic        h_wrap;
    logic        v_wrap;

    always_comb begin
        h_wrap   = ({1'b0, hcount_q} == H_LAST);
        v_wrap   = ({1'b0, vcount_q} == V_LAST);
        hcount_d = h_wrap ? 11'd0 : hcount_q + 11'd1;
        vcount_d = vcount_q;
        if (h_wrap) begin
            vcount_d = v_wrap ? 10'd0 : vcount_q + 10'd1;
        end
    end

    // ------------------------------------------------------------------
    // Sync / blank / frame decode
    //
    // Decoded from the next-state counter values and registered together
    // with the counters, so every registered output describes exactly the
    // counter values presented in the same cycle (no one-clock skew).
    // vsync can only change when vcount changes, i.e. at hcount==0.
    // ------------------------------------------------------------------
    logic       hs_q,   hs_d;
    logic       vs_q,   vs_d;
    logic       bl_q,   bl_d;
    logic       tick_q, tick_d;
    logic [7:0] fcnt_q, fcnt_d;

    always_comb begin
        hs_d   = !(({1'b0, hcount_d} >= HS_START) && ({1'b0, hcount_d} < HS_END));
        vs_d   = !(({1'b0, vcount_d} >= VS_START) && ({1'b0, vcount_d} < VS_END));
        bl_d   = ({1'b0, hcount_d} >= H_ACT_W) || ({1'b0, vcount_d} >= V_ACT_W);
        // The tick marks the transition into (0,0); the reset state itself
        // is (0,0) but never produced by a wrap, so it carries no tick.
        tick_d = h_wrap && v_wrap;
        fcnt_d = tick_d ? fcnt_q + 8'd1 : fcnt_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hcount_q <= 11'd0;
            vcount_q <= 10'd0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            bl_q     <= 1'b0;
            tick_q   <= 1'b0;
            fcnt_q   <= 8'd0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            bl_q     <= bl_d;
            tick_q   <= tick_d;
            fcnt_q   <= fcnt_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign blank       = bl_q;
    assign frame_tick  = tick_q;
    assign frame_count = fcnt_q;

    // ------------------------------------------------------------------
    // Delayed sync / blank
    //
    // Shift registers fed from the registered undelayed signals. They reset
    // to the idle level (1,1,1) so the monitor sees inactive sync and blank
    // video until real raster values have propagated through.
    // ------------------------------------------------------------------
    generate
        if (SYNC_DELAY == 0) begin : g_sync_nodly
            assign hsync_d = hs_q;
            assign vsync_d = vs_q;
            assign blank_d = bl_q;
        end else begin : g_sync_dly
            logic [SYNC_DELAY-1:0] hs_sr_q;
            logic [SYNC_DELAY-1:0] vs_sr_q;
            logic [SYNC_DELAY-1:0] bl_sr_q;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    hs_sr_q <= '1;
                    vs_sr_q <= '1;
                    bl_sr_q <= '1;
                end else begin
                    hs_sr_q[0] <= hs_q;
                    vs_sr_q[0] <= vs_q;
                    bl_sr_q[0] <= bl_q;
                    for (int i = 1; i < SYNC_DELAY; i++) begin
                        hs_sr_q[i] <= hs_sr_q[i-1];
                        vs_sr_q[i] <= vs_sr_q[i-1];
                        bl_sr_q[i] <= bl_sr_q[i-1];
                    end
                end
            end

            assign hsync_d = hs_sr_q[SYNC_DELAY-1];
            assign vsync_d = vs_sr_q[SYNC_DELAY-1];
            assign blank_d = bl_sr_q[SYNC_DELAY-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Test pattern
    //
    // Eight 128-pixel bars selected by hcount[9:7]. The colour is formed
    // from the current registered counters/blank and then passed through a
    // delay line of the same depth as the sync copies, so it lines up with
    // blank_d at the monitor.
    // ------------------------------------------------------------------
`ifdef XVGA_TEST_PATTERN_EN
    logic [11:0] pat_src;

    always_comb begin
        pat_src = 12'h000;
        if (!bl_q) begin
            case (hcount_q[9:7])
                3'd0: pat_src = 12'hFFF;
                3'd1: pat_src = 12'hFF0;
                3'd2: pat_src = 12'h0FF;
                3'd3: pat_src = 12'h0F0;
                3'd4: pat_src = 12'hF0F;
                3'd5: pat_src = 12'hF00;
                3'd6: pat_src = 12'h00F;
                3'd7: pat_src = 12'h000;
            endcase
        end
    end

    generate
        if (SYNC_DELAY == 0) begin : g_pat_nodly
            assign pattern_pixel = pat_src;
        end else begin : g_pat_dly
            logic [11:0] pat_sr_q [SYNC_DELAY];

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < SYNC_DELAY; i++) begin
                        pat_sr_q[i] <= 12'h000;
                    end
                end else begin
                    pat_sr_q[0] <= pat_src;
                    for (int i = 1; i < SYNC_DELAY; i++) begin
                        pat_sr_q[i] <= pat_sr_q[i-1];
                    end
                end
            end

            assign pattern_pixel = pat_sr_q[SYNC_DELAY-1];
        end
    endgenerate
`else
    assign pattern_pixel = 12'h000;
`endif

endmodule

// File: tb/tb_xvga_timing.sv
// ----------------------------------------------------------------------------
// tb_xvga_timing
//
// Two instances share one clock:
//   dut_a : default XVGA parameters, SYNC_DELAY=2 (line-level behaviour,
//           a directed reset at hcount=500/vcount=2 and a random reset).
//   dut_b : a tiny raster (16 x 11), SYNC_DELAY=0, run for more than 256
//           frames so vsync, frame_tick and the frame_count wrap are seen,
//           followed by a random mid-frame reset.
//
// The reference model describes every output as a function of the number
// of counting clocks t since reset release: hcount = t mod H_TOTAL,
// vcount = (t div H_TOTAL) mod V_TOTAL, delayed outputs are the raster at
// t-D (idle before that), frame_count = (t div frame) mod 256.
// ----------------------------------------------------------------------------
module tb_xvga_timing;

    localparam int W     = 48;
    localparam int N_CYC = 46400;

`ifdef XVGA_TEST_PATTERN_EN
    localparam bit PAT_EN = 1'b1;
`else
    localparam bit PAT_EN = 1'b0;
`endif

    typedef struct packed {
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
        int d;
    } cfg_t;

    localparam cfg_t CFG_A = '{ha: 1024, hf: 24, hs: 136, hb: 160,
                               va: 768,  vf: 3,  vs: 6,   vb: 29, d: 2};
    localparam cfg_t CFG_B = '{ha: 8, hf: 2, hs: 3, hb: 3,
                               va: 6, vf: 1, vs: 2, vb: 2, d: 0};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_a_n;
    logic rst_b_n;

    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [10:0] a_hcount, b_hcount;
    logic [9:0]  a_vcount, b_vcount;
    logic        a_hsync, a_vsync, a_blank, a_hsync_d, a_vsync_d, a_blank_d, a_tick;
    logic        b_hsync, b_vsync, b_blank, b_hsync_d, b_vsync_d, b_blank_d, b_tick;
    logic [7:0]  a_fcnt, b_fcnt;
    logic [11:0] a_pat, b_pat;

    xvga_timing dut_a (
        .clock        (clk),
        .reset        (rst_a_n),
        .hcount       (a_hcount),
        .vcount       (a_vcount),
        .hsync        (a_hsync),
        .vsync        (a_vsync),
        .blank        (a_blank),
        .hsync_d      (a_hsync_d),
        .vsync_d      (a_vsync_d),
        .blank_d      (a_blank_d),
        .frame_tick   (a_tick),
        .frame_count  (a_fcnt),
        .pattern_pixel(a_pat)
    );

    xvga_timing #(
        .H_ACTIVE  (8),
        .H_FP      (2),
        .H_SYNC    (3),
        .H_BP      (3),
        .V_ACTIVE  (6),
        .V_FP      (1),
        .V_SYNC    (2),
        .V_BP      (2),
        .SYNC_DELAY(0)
    ) dut_b (
        .clock        (clk),
        .reset        (rst_b_n),
        .hcount       (b_hcount),
        .vcount       (b_vcount),
        .hsync        (b_hsync),
        .vsync        (b_vsync),
        .blank        (b_blank),
        .hsync_d      (b_hsync_d),
        .vsync_d      (b_vsync_d),
        .blank_d      (b_blank_d),
        .frame_tick   (b_tick),
        .frame_count  (b_fcnt),
        .pattern_pixel(b_pat)
    );

    // ---------------- reference model ----------------
    function automatic logic [11:0] bar_colour(int h);
        int bar;
        bar = (h / 128) % 8;
        case (bar)
            0:       return 12'hFFF;
            1:       return 12'hFF0;
            2:       return 12'h0FF;
            3:       return 12'h0F0;
            4:       return 12'hF0F;
            5:       return 12'hF00;
            6:       return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

    // {hsync, vsync, blank, pattern} of the raster position reached after t clocks
    function automatic logic [14:0] raster(int t, cfg_t c);
        int ht, vt, h, v;
        logic hs, vs, bl;
        logic [11:0] pat;
        ht  = c.ha + c.hf + c.hs + c.hb;
        vt  = c.va + c.vf + c.vs + c.vb;
        h   = t % ht;
        v   = (t / ht) % vt;
        bl  = (h >= c.ha) || (v >= c.va);
        hs  = !((h >= c.ha + c.hf) && (h < c.ha + c.hf + c.hs));
        vs  = !((v >= c.va + c.vf) && (v < c.va + c.vf + c.vs));
        pat = (PAT_EN && !bl) ? bar_colour(h) : 12'h000;
        return {hs, vs, bl, pat};
    endfunction

    function automatic logic [W-1:0] model(int t, cfg_t c);
        int ht, vt, frame;
        logic [10:0] hc;
        logic [9:0]  vc;
        logic [14:0] now, dly;
        logic        tick;
        logic [7:0]  fc;
        ht    = c.ha + c.hf + c.hs + c.hb;
        vt    = c.va + c.vf + c.vs + c.vb;
        frame = ht * vt;
        hc    = 11'(t % ht);
        vc    = 10'((t / ht) % vt);
        now   = raster(t, c);
        if (t >= c.d) dly = raster(t - c.d, c);
        else          dly = {3'b111, 12'h000};
        tick  = (t > 0) && (t % frame == 0);
        fc    = 8'((t / frame) % 256);
        return {hc, vc, now[14:12], dly[14:12], tick, fc, dly[11:0]};
    endfunction

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_a_q[$];
    logic [W-1:0] exp_b_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    always @(negedge clk) begin
        logic [W-1:0] e, g;
        if (exp_a_q.size() > 0) begin
            e = exp_a_q.pop_front();
            g = {a_hcount, a_vcount, a_hsync, a_vsync, a_blank,
                 a_hsync_d, a_vsync_d, a_blank_d, a_tick, a_fcnt, a_pat};
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL dut_a_outputs @%0t got=%h expected=%h", $time, g, e);
            end
        end
        if (exp_b_q.size() > 0) begin
            e = exp_b_q.pop_front();
            g = {b_hcount, b_vcount, b_hsync, b_vsync, b_blank,
                 b_hsync_d, b_vsync_d, b_blank_d, b_tick, b_fcnt, b_pat};
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL dut_b_outputs @%0t got=%h expected=%h", $time, g, e);
            end
        end
    end

    // ---------------- driver ----------------
    // Each step runs just after a rising edge: first account for the edge
    // (it counted if reset was released), then optionally change reset,
    // then push the expected outputs for the state now visible.
    initial begin
        int  t_a, t_b, hold_a, hold_b, rst_at_a, rst_at_b;
        bit  did_dir;
        t_a      = 0;
        t_b      = 0;
        hold_a   = 5;
        hold_b   = 5;
        did_dir  = 1'b0;
        rst_at_a = $urandom_range(6000, 40000);
        rst_at_b = 45056 + $urandom_range(300, 900);
        rst_a_n  = 1'b0;
        rst_b_n  = 1'b0;

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(posedge clk);
            #1;
            if (hold_a == 0) t_a++;
            if (hold_b == 0) t_b++;

            if (hold_a > 0) begin
                hold_a--;
                if (hold_a == 0) rst_a_n = 1'b1;
            end else if ((!did_dir && t_a == 2 * 1344 + 500) || t_a == rst_at_a) begin
                did_dir = 1'b1;
                rst_a_n = 1'b0;
                t_a     = 0;
                hold_a  = $urandom_range(1, 4);
            end

            if (hold_b > 0) begin
                hold_b--;
                if (hold_b == 0) rst_b_n = 1'b1;
            end else if (t_b == rst_at_b) begin
                rst_b_n = 1'b0;
                t_b     = 0;
                hold_b  = $urandom_range(1, 4);
            end

            exp_a_q.push_back(model(t_a, CFG_A));
            exp_b_q.push_back(model(t_b, CFG_B));
        end

        @(negedge clk);
        #1;
        n_tests++;
        if (exp_a_q.size() + exp_b_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d expected=0",
                     exp_a_q.size() + exp_b_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/xvga_timing.md
Name: xvga_timing

Overview:
- Generates the XVGA raster: pixel counters plus horizontal sync, vertical sync and blanking.
- Its counter and sync outputs feed the graphics compositor's hcount/vcount/hsync/vsync/blank inputs.
- Also provides sync/blank copies delayed by a fixed number of cycles, so the monitor-side signals can match the latency of the compositor's sprite ROMs.
- Also provides a frame tick and frame counter for game-logic animation.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (clocks)
- H_SYNC, 136, hsync pulse width (clocks)
- H_BP, 160, horizontal back porch (clocks); H_TOTAL = sum = 1344
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vsync pulse width (lines)
- V_BP, 29, vertical back porch (lines); V_TOTAL = sum = 806
- SYNC_DELAY, 2, pipeline depth of the delayed sync/blank outputs (0 allowed)

Ports:
- clock  in  1  pixel clock (65 MHz)
- reset  in  1  asynchronous, active-low reset
- hcount  out  11  horizontal pixel index, 0..H_TOTAL-1
- vcount  out  10  vertical line index, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, active low, aligned with hcount
- vsync  out  1  vertical sync, active low, aligned with vcount
- blank  out  1  1 outside the active area, aligned with counters
- hsync_d  out  1  hsync delayed SYNC_DELAY clocks
- vsync_d  out  1  vsync delayed SYNC_DELAY clocks
- blank_d  out  1  blank delayed SYNC_DELAY clocks
- frame_tick  out  1  one-clock pulse at start of each frame
- frame_count  out  8  frames elapsed, wraps 255->0
- pattern_pixel  out  12  test colour bars (see Optional Feature)

Behaviour:
- All outputs are registered. Every output is a pure function of the counter values it is presented with in the same cycle; there is no skew between counters and hsync/vsync/blank.
- Reset (reset==0, asynchronous):
  - hcount=0, vcount=0
  - hsync=1, vsync=1, blank=0 (pixel 0,0 is active)
  - hsync_d=1, vsync_d=1, blank_d=1
  - frame_tick=0, frame_count=0, pattern_pixel=0
- Reset release: counting starts on the first rising edge after reset deasserts. Reset mid-frame returns to the reset state immediately; there is no partial-line flush.
- Horizontal counter: hcount increments by 1 each clock. At H_TOTAL-1 it wraps to 0.
- Vertical counter:
  - vcount increments only on the clock where hcount wraps.
  - At vcount==V_TOTAL-1 with hcount wrapping, vcount wraps to 0.
- blank = (hcount >= H_ACTIVE) || (vcount >= V_ACTIVE).
- hsync = 0 iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (default 1048..1183).
- vsync = 0 iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (default 771..776). vsync changes only at hcount==0.
- frame_tick:
  - 1 for exactly the one clock in which hcount==0 and vcount==0 are presented after a wrap.
  - No tick in the cycle directly after reset.
  - Period is H_TOTAL*V_TOTAL = 1,083,264 clocks.
- frame_count increments in the same cycle frame_tick asserts. Modulo 256.
- Delayed outputs:
  - Shift registers of depth SYNC_DELAY, filled from the undelayed registered hsync/vsync/blank.
  - SYNC_DELAY==0: the delayed outputs equal the undelayed outputs.
  - After reset they show the idle values (1,1,1) until SYNC_DELAY clocks have elapsed.
- Widths: counters compare at full width, with no truncation. Parameters must give H_TOTAL <= 2048 and V_TOTAL <= 1024.

Optional Feature:
- Macro: XVGA_TEST_PATTERN_EN.
- Defined: pattern_pixel is a registered 8-bar colour pattern, aligned with blank_d, i.e. delayed SYNC_DELAY clocks like the other delayed outputs.
  - Bar index = hcount[9:7].
  - Colours in order: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - Output is 12'h000 whenever blank is 1.
- Undefined: pattern_pixel is tied to 12'h000 and no pattern logic is synthesised. The port remains present in both cases.

Test Plan:
- Reset held low for 5 clocks, then released -> all outputs hold reset values; first clock gives hcount=1, vcount=0, blank=0, frame_tick=0.
- Run one line -> hsync low for exactly 136 clocks starting at hcount=1048; blank rises at hcount=1024; hcount wraps 1343->0 while vcount goes 0->1.
- Run 806 lines -> vsync low for lines 771..776 with transitions at hcount=0; frame_tick pulses once per 1,083,264 clocks; frame_count steps 0->1->2.
- Run 256 frames (or force counters near the frame end) -> frame_count wraps 255->0 in the same cycle as frame_tick.
- SYNC_DELAY=2 vs 0 -> hsync_d/vsync_d/blank_d equal hsync/vsync/blank shifted by exactly 2 clocks (resp. 0); assert reset at hcount=500, vcount=300 -> immediate return to 0,0 and idle delayed values.
- With XVGA_TEST_PATTERN_EN -> pixel hcount=0 gives FFF, 128 gives FF0, 900 gives 000, 1030 (blanked) gives 000; without the macro, pattern_pixel stays 000 throughout.
